cpu_clk_ctrl: RTL

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl_pkg.sv | 29 ++
 rtl/cpu_clk_ctrl_btn_debounce.sv | 51 +++++
 rtl/cpu_clk_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable controller: FSM encodings,
// default widths and the divider tap clamp helper.
package cpu_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    typedef struct packed {
        state_t state;
        logic   run_lvl;
        logic   step_lvl;
    } dbg_t;

    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_BASE_TAP  = 22;
    localparam int DEF_TAP_STEP  = 2;
    localparam int DEF_RSEL_W    = 2;
    localparam int DEF_TEST_TAP  = 25;
    localparam int DEF_DB_CYCLES = 1000000;
    localparam int STEP_CNT_W    = 32;

    function automatic int clamp_tap(input int tap, input int max_tap);
        return (tap > max_tap) ? max_tap : tap;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-count debouncer and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int DBW = $clog2(DB_CYCLES + 1);

    logic [1:0]     r_sync;
    logic [DBW-1:0] r_cnt;
    logic           r_level;
    logic           r_press;
    logic           w_diff;
    logic           w_done;

    // r_cnt counts consecutive synchronised samples that disagree with the level
    assign w_diff = (r_sync[1] != r_level);
    assign w_done = w_diff && (r_cnt == DBW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= w_done && r_sync[1];
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + DBW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: run/halt/single-step control, rate-selectable
// divider, free-running test tick and an issued-pulse counter.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int BASE_TAP  = DEF_BASE_TAP,
    parameter int TAP_STEP  = DEF_TAP_STEP,
    parameter int RSEL_W    = DEF_RSEL_W,
    parameter int TEST_TAP  = DEF_TEST_TAP,
    parameter int DB_CYCLES = DEF_DB_CYCLES,
    parameter int RESET_RUN = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  btn_step,
    input  logic                  btn_run,
    input  logic [RSEL_W-1:0]     rate_sel,
    output logic                  cpu_en,
    output logic                  test_tick,
    output logic                  running,
    output logic [STEP_CNT_W-1:0] step_cnt,
    output dbg_t                  dbg
);

    state_t                r_state;
    state_t                w_next;
    logic [RSEL_W-1:0]     r_rsel;
    logic [CNT_WIDTH-1:0]  r_div;
    logic [CNT_WIDTH-1:0]  w_mask;
    logic [TEST_TAP-1:0]   r_tt;
    logic                  r_cpu_en;
    logic                  r_test_tick;
    logic                  r_running;
    logic [STEP_CNT_W-1:0] r_step_cnt;
    logic                  w_run_press;
    logic                  w_step_press;
    logic                  w_run_lvl;
    logic                  w_step_lvl;
    logic                  w_rsel_chg;
    logic                  w_hit;
    logic                  w_div_pulse;
    logic                  w_en_next;
    int                    w_tap;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk     (clk),
        .rstn    (rstn),
        .i_btn   (btn_run),
        .o_level (w_run_lvl),
        .o_press (w_run_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk     (clk),
        .rstn    (rstn),
        .i_btn   (btn_step),
        .o_level (w_step_lvl),
        .o_press (w_step_press)
    );

    always_comb begin
        w_tap  = clamp_tap(BASE_TAP + int'(r_rsel) * TAP_STEP, CNT_WIDTH);
        w_mask = '0;
        for (int i = 0; i < CNT_WIDTH; i++) begin
            if (i < w_tap) w_mask[i] = 1'b1;
        end
    end

    // A rate change or a run press that leaves RUN swallows a pulse due this cycle
    assign w_rsel_chg  = (rate_sel != r_rsel);
    assign w_hit       = ((r_div & w_mask) == w_mask);
    assign w_div_pulse = (r_state == ST_RUN) && !w_run_press && !w_rsel_chg && w_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= (RESET_RUN != 0) ? ST_RUN : ST_HALT;
        end else begin
            r_state <= w_next;
        end
    end

    // Run press wins over a simultaneous step press
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (w_run_press)       w_next = ST_RUN;
                else if (w_step_press) w_next = ST_STEP;
            end
            ST_RUN:  if (w_run_press) w_next = ST_HALT;
            ST_STEP: w_next = ST_HALT;
            default: w_next = ST_HALT;
        endcase
        w_en_next = (w_next == ST_STEP) || w_div_pulse;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsel      <= '0;
            r_div       <= '0;
            r_tt        <= '0;
            r_cpu_en    <= 1'b0;
            r_test_tick <= 1'b0;
            r_running   <= (RESET_RUN != 0);
            r_step_cnt  <= '0;
        end else begin
            r_rsel <= rate_sel;
            if ((r_state != ST_RUN) || w_rsel_chg || w_hit) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + CNT_WIDTH'(1);
            end
            r_tt        <= r_tt + TEST_TAP'(1);
            r_test_tick <= &r_tt;
            r_cpu_en    <= w_en_next;
            r_running   <= (w_next == ST_RUN);
            r_step_cnt  <= r_step_cnt + STEP_CNT_W'(w_en_next);
        end
    end

    assign cpu_en       = r_cpu_en;
    assign test_tick    = r_test_tick;
    assign running      = r_running;
    assign step_cnt     = r_step_cnt;
    assign dbg.state    = r_state;
    assign dbg.run_lvl  = w_run_lvl;
    assign dbg.step_lvl = w_step_lvl;

endmodule
